// File: rtl/vx_elastic_buffer_pkg.sv
// ============================================================================
// vx_elastic_buffer_pkg: parameter legality helpers for the elastic buffer.
// Revision 1.0
// ============================================================================
`default_nettype none

package vx_elastic_buffer_pkg;

  // Smallest depth handled by the FIFO-backed implementation.
  localparam int c_fifo_min_size = 4;

  function automatic bit size_is_legal(input int size);
    return ((size >= 0) && (size <= 2)) ||
           ((size >= c_fifo_min_size) && ((size & (size - 1)) == 0));
  endfunction

  function automatic bit flag_is_legal(input int value);
    return (value == 0) || (value == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_elastic_buffer_fifo_queue.sv
// ============================================================================
// VX_fifo_queue: power-of-two circular FIFO with async or registered read.
// Revision 1.0
// ============================================================================
`default_nettype none

module VX_fifo_queue #(
  parameter int DATAW      = 1,
  parameter int SIZE       = 4,
  parameter int OUTPUT_REG = 0,
  parameter int LUTRAM     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DATAW-1:0] i_data,
  output logic [DATAW-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int ADDRW = $clog2(SIZE);
  localparam logic [ADDRW:0] c_depth = (ADDRW + 1)'(SIZE);
  localparam logic [ADDRW:0] c_one   = (ADDRW + 1)'(1);

  logic [DATAW-1:0] r_mem [SIZE];
  logic [ADDRW-1:0] r_rd_ptr;
  logic [ADDRW-1:0] r_wr_ptr;
  logic [ADDRW:0]   r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + ADDRW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + ADDRW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);

  if ((OUTPUT_REG != 0) || (LUTRAM == 0)) begin : g_reg_read
    logic [ADDRW-1:0] w_rd_ptr_next;
    logic [DATAW-1:0] r_dout;

    assign w_rd_ptr_next = r_rd_ptr + ADDRW'(1);

    // Head is prefetched: a push that becomes the new head bypasses the memory.
    always_ff @(posedge clk) begin
      if (i_push && (o_empty || ((r_count == c_one) && i_pop))) begin
        r_dout <= i_data;
      end else if (i_pop) begin
        r_dout <= r_mem[w_rd_ptr_next];
      end
    end

    assign o_data = r_dout;
  end else begin : g_async_read
    assign o_data = r_mem[r_rd_ptr];
  end

endmodule

`default_nettype wire

// File: rtl/vx_elastic_buffer.sv
// ============================================================================
// vx_elastic_buffer: valid/ready elastic stage, depth selected by SIZE.
// Revision 1.0
// ============================================================================
`default_nettype none

module vx_elastic_buffer #(
  parameter int DATAW      = 1,
  parameter int SIZE       = 2,
  parameter int OUTPUT_REG = 0,
  parameter int LUTRAM     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out
);

  import vx_elastic_buffer_pkg::*;

  if (!size_is_legal(SIZE) || !flag_is_legal(OUTPUT_REG) || !flag_is_legal(LUTRAM)) begin : g_param_check
    $error("vx_elastic_buffer: illegal parameters SIZE=%0d OUTPUT_REG=%0d LUTRAM=%0d",
           SIZE, OUTPUT_REG, LUTRAM);
  end

  if (SIZE == 0) begin : g_bypass
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ reset;

    assign valid_out = valid_in;
    assign data_out  = data_in;
    assign ready_in  = ready_out;
  end else if (SIZE == 1) begin : g_pipe
    logic             r_valid;
    logic [DATAW-1:0] r_data;
    logic             w_ready;

    assign w_ready = !r_valid || ready_out;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid <= 1'b0;
      end else if (w_ready) begin
        r_valid <= valid_in;
      end
    end

    always_ff @(posedge clk) begin
      if (w_ready && valid_in) r_data <= data_in;
    end

    assign ready_in  = w_ready;
    assign valid_out = r_valid;
    assign data_out  = r_data;
  end else if (SIZE == 2) begin : g_skid
    logic             r_valid;
    logic             r_skid_valid;
    logic [DATAW-1:0] r_data;
    logic [DATAW-1:0] r_skid_data;
    logic             w_out_free;

    assign w_out_free = !r_valid || ready_out;

    // ready_in is the inverse of the skid flag, so it never sees ready_out combinationally.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_valid      <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_out_free) begin
        if (r_skid_valid) begin
          r_valid      <= 1'b1;
          r_skid_valid <= 1'b0;
        end else begin
          r_valid <= valid_in;
        end
      end else if (valid_in && !r_skid_valid) begin
        r_skid_valid <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (w_out_free) begin
        r_data <= r_skid_valid ? r_skid_data : data_in;
      end
      if (!w_out_free && valid_in && !r_skid_valid) begin
        r_skid_data <= data_in;
      end
    end

    assign ready_in  = !r_skid_valid;
    assign valid_out = r_valid;
    assign data_out  = r_data;
  end else begin : g_fifo
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    assign w_push = valid_in && !w_full;
    assign w_pop  = valid_out && ready_out;

    VX_fifo_queue #(
      .DATAW      (DATAW),
      .SIZE       (SIZE),
      .OUTPUT_REG (OUTPUT_REG),
      .LUTRAM     (LUTRAM)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (data_in),
      .o_data  (data_out),
      .o_empty (w_empty),
      .o_full  (w_full)
    );

    assign ready_in  = !w_full;
    assign valid_out = !w_empty;
  end

endmodule

`default_nettype wire

// File: tb/tb_vx_elastic_buffer.sv
// ============================================================================
// tb_vx_elastic_buffer: directed and random checks across SIZE 0/1/2/4/8.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_vx_elastic_buffer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         valid_in = 1'b0;
  logic         ready_out = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic [N-1:0] rin;
  logic [N-1:0] vout;
  logic [7:0]   dout [N];

  int errors = 0;
  int checks = 0;

  logic [7:0] refq [N][$];
  int         sz [N] = '{0, 1, 2, 4, 8};

  always #5 clk = ~clk;

  vx_elastic_buffer #(.DATAW(8), .SIZE(0)) u_s0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rin[0]), .data_in(data_in),
    .valid_out(vout[0]), .ready_out(ready_out), .data_out(dout[0]));
  vx_elastic_buffer #(.DATAW(8), .SIZE(1)) u_s1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rin[1]), .data_in(data_in),
    .valid_out(vout[1]), .ready_out(ready_out), .data_out(dout[1]));
  vx_elastic_buffer #(.DATAW(8), .SIZE(2)) u_s2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rin[2]), .data_in(data_in),
    .valid_out(vout[2]), .ready_out(ready_out), .data_out(dout[2]));
  vx_elastic_buffer #(.DATAW(8), .SIZE(4), .OUTPUT_REG(0), .LUTRAM(1)) u_s4 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rin[3]), .data_in(data_in),
    .valid_out(vout[3]), .ready_out(ready_out), .data_out(dout[3]));
  vx_elastic_buffer #(.DATAW(8), .SIZE(8), .OUTPUT_REG(1), .LUTRAM(0)) u_s8 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(rin[4]), .data_in(data_in),
    .valid_out(vout[4]), .ready_out(ready_out), .data_out(dout[4]));

  // Inputs change just after a falling edge; outputs are sampled 4 ns later.
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1; data_in = 8'h00;
    repeat (2) @(negedge clk);
    #4;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (vout[i] !== 1'b0) begin
        errors++; $display("FAIL reset_valid_out[size=%0d]: got %b expected 0", sz[i], vout[i]);
      end
      checks++;
      if (rin[i] !== 1'b1) begin
        errors++; $display("FAIL reset_ready_in[size=%0d]: got %b expected 1", sz[i], rin[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_size0_comb;
    do_reset();
    @(negedge clk);
    valid_in = 1'b1; data_in = 8'h3C; ready_out = 1'b0;
    #4;
    checks++;
    if (vout[0] !== 1'b1 || dout[0] !== 8'h3C || rin[0] !== 1'b0) begin
      errors++; $display("FAIL s0_comb_stall: got v=%b d=%h r=%b expected v=1 d=3c r=0", vout[0], dout[0], rin[0]);
    end
    @(negedge clk);
    valid_in = 1'b0; data_in = 8'h5A; ready_out = 1'b1;
    #4;
    checks++;
    if (vout[0] !== 1'b0 || dout[0] !== 8'h5A || rin[0] !== 1'b1) begin
      errors++; $display("FAIL s0_comb_pass: got v=%b d=%h r=%b expected v=0 d=5a r=1", vout[0], dout[0], rin[0]);
    end
  endtask

  task automatic test_s2_stream;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid_in = (c < 8); data_in = 8'(c); ready_out = 1'b1;
      #4;
      checks++;
      if (rin[2] !== 1'b1) begin
        errors++; $display("FAIL s2_stream_ready[c=%0d]: got %b expected 1", c, rin[2]);
      end
      if (c >= 1 && c <= 8) begin
        checks++;
        if (vout[2] !== 1'b1 || dout[2] !== 8'(c - 1)) begin
          errors++; $display("FAIL s2_stream_data[c=%0d]: got v=%b d=%h expected v=1 d=%h", c, vout[2], dout[2], 8'(c - 1));
        end
      end else if (c == 9) begin
        checks++;
        if (vout[2] !== 1'b0) begin
          errors++; $display("FAIL s2_stream_drained: got v=%b expected 0", vout[2]);
        end
      end
    end
  endtask

  task automatic test_s2_skid;
    logic       exp_v  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d  [6] = '{8'h00, 8'h0A, 8'h0A, 8'h0A, 8'h0B, 8'h00};
    logic       exp_r  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       drv_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] drv_d  [6] = '{8'h0A, 8'h0B, 8'h0C, 8'h0C, 8'h00, 8'h00};
    logic       drv_ro [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      valid_in = drv_v[c]; data_in = drv_d[c]; ready_out = drv_ro[c];
      #4;
      checks++;
      if (rin[2] !== exp_r[c] || vout[2] !== exp_v[c] || (exp_v[c] && dout[2] !== exp_d[c])) begin
        errors++;
        $display("FAIL s2_skid[c=%0d]: got r=%b v=%b d=%h expected r=%b v=%b d=%h",
                 c, rin[2], vout[2], dout[2], exp_r[c], exp_v[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_s1_accept_pop;
    logic       exp_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d  [5] = '{8'h00, 8'h05, 8'h06, 8'h06, 8'h00};
    logic       exp_r  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       drv_v  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] drv_d  [5] = '{8'h05, 8'h06, 8'h00, 8'h00, 8'h00};
    logic       drv_ro [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_in = drv_v[c]; data_in = drv_d[c]; ready_out = drv_ro[c];
      #4;
      checks++;
      if (rin[1] !== exp_r[c] || vout[1] !== exp_v[c] || (exp_v[c] && dout[1] !== exp_d[c])) begin
        errors++;
        $display("FAIL s1_accept_pop[c=%0d]: got r=%b v=%b d=%h expected r=%b v=%b d=%h",
                 c, rin[1], vout[1], dout[1], exp_r[c], exp_v[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_fifo_fill;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      valid_in  = (c <= 4);
      data_in   = (c == 4) ? 8'h99 : 8'(8'h10 + c);
      ready_out = (c >= 5);
      #4;
      if (c <= 4) begin
        checks++;
        if (rin[3] !== (c < 4)) begin
          errors++; $display("FAIL s4_fill_ready[c=%0d]: got %b expected %b", c, rin[3], (c < 4));
        end
      end
      if (c == 1 || c == 4) begin
        checks++;
        if (vout[3] !== 1'b1 || dout[3] !== 8'h10) begin
          errors++; $display("FAIL s4_fill_head[c=%0d]: got v=%b d=%h expected v=1 d=10", c, vout[3], dout[3]);
        end
      end
      if (c >= 5 && c <= 8) begin
        checks++;
        if (vout[3] !== 1'b1 || dout[3] !== 8'(8'h10 + c - 5)) begin
          errors++; $display("FAIL s4_drain[c=%0d]: got v=%b d=%h expected v=1 d=%h", c, vout[3], dout[3], 8'(8'h10 + c - 5));
        end
      end
      if (c == 9) begin
        checks++;
        if (vout[3] !== 1'b0) begin
          errors++; $display("FAIL s4_empty_after: got v=%b expected 0", vout[3]);
        end
      end
    end
  endtask

  task automatic test_fifo_push_pop;
    logic       exp_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] exp_d  [5] = '{8'h00, 8'h21, 8'h22, 8'h22, 8'h00};
    logic       drv_v  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] drv_d  [5] = '{8'h21, 8'h22, 8'h00, 8'h00, 8'h00};
    logic       drv_ro [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      valid_in = drv_v[c]; data_in = drv_d[c]; ready_out = drv_ro[c];
      #4;
      for (int i = 3; i < N; i++) begin
        checks++;
        if (vout[i] !== exp_v[c] || (exp_v[c] && dout[i] !== exp_d[c])) begin
          errors++;
          $display("FAIL fifo_push_pop[size=%0d c=%0d]: got v=%b d=%h expected v=%b d=%h",
                   sz[i], c, vout[i], dout[i], exp_v[c], exp_d[c]);
        end
      end
    end
  endtask

  task automatic test_reset_flush;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      reset     = (c == 2);
      valid_in  = (c < 2);
      data_in   = 8'(8'h31 + c);
      ready_out = (c >= 3);
      #4;
      if (c >= 3) begin
        for (int i = 1; i < N; i++) begin
          checks++;
          if (vout[i] !== 1'b0 || (c == 3 && rin[i] !== 1'b1)) begin
            errors++;
            $display("FAIL reset_flush[size=%0d c=%0d]: got v=%b r=%b expected v=0 r=1", sz[i], c, vout[i], rin[i]);
          end
        end
      end
    end
  endtask

  task automatic test_random;
    logic       prev_v [N];
    logic [7:0] prev_d [N];
    logic       prev_ro;
    do_reset();
    for (int i = 0; i < N; i++) begin
      refq[i].delete();
      prev_v[i] = 1'b0;
      prev_d[i] = 8'h00;
    end
    prev_ro = 1'b0;
    for (int c = 0; c < 10020; c++) begin
      @(negedge clk);
      if (c < 10000) begin
        valid_in  = 1'($urandom_range(0, 1));
        ready_out = 1'($urandom_range(0, 1));
      end else begin
        valid_in  = 1'b0;
        ready_out = 1'b1;
      end
      data_in = 8'($urandom);
      #4;
      checks++;
      if (rin[0] !== ready_out || vout[0] !== valid_in || (valid_in && dout[0] !== data_in)) begin
        errors++;
        $display("FAIL rand_s0[c=%0d]: got r=%b v=%b d=%h expected r=%b v=%b d=%h",
                 c, rin[0], vout[0], dout[0], ready_out, valid_in, data_in);
      end
      for (int i = 1; i < N; i++) begin
        if (prev_v[i] && !prev_ro) begin
          checks++;
          if (vout[i] !== 1'b1 || dout[i] !== prev_d[i]) begin
            errors++;
            $display("FAIL rand_hold[size=%0d c=%0d]: got v=%b d=%h expected v=1 d=%h", sz[i], c, vout[i], dout[i], prev_d[i]);
          end
        end
        if (vout[i] && ready_out) begin
          checks++;
          if (refq[i].size() == 0) begin
            errors++; $display("FAIL rand_spurious[size=%0d c=%0d]: got d=%h expected no output", sz[i], c, dout[i]);
          end else begin
            if (dout[i] !== refq[i][0]) begin
              errors++; $display("FAIL rand_data[size=%0d c=%0d]: got %h expected %h", sz[i], c, dout[i], refq[i][0]);
            end
            void'(refq[i].pop_front());
          end
        end
        if (valid_in && rin[i]) begin
          refq[i].push_back(data_in);
          checks++;
          if (refq[i].size() > sz[i]) begin
            errors++; $display("FAIL rand_overflow[size=%0d c=%0d]: got %0d entries expected <= %0d", sz[i], c, refq[i].size(), sz[i]);
          end
        end
        prev_v[i] = vout[i];
        prev_d[i] = dout[i];
      end
      prev_ro = ready_out;
    end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (refq[i].size() != 0 || vout[i] !== 1'b0) begin
        errors++;
        $display("FAIL rand_drain[size=%0d]: got %0d pending v=%b expected 0 pending v=0", sz[i], refq[i].size(), vout[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_size0_comb();
    test_s2_stream();
    test_s2_skid();
    test_s1_accept_pop();
    test_fifo_fill();
    test_fifo_push_pop();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_elastic_buffer.md
VX_ELASTIC_BUFFER -- requirements
Module: VX_elastic_buffer

Interface
REQ-001 SHALL have parameter DATAW, default 1: payload width in bits.
REQ-002 SHALL have parameter SIZE, default 2: storage depth; legal values are 0, 1, 2, or a power of 2 of at least 4.
REQ-003 SHALL have parameter OUTPUT_REG, default 0: for SIZE>=4 only, registers data_out.
REQ-004 SHALL have parameter LUTRAM, default 1: for SIZE>=4 only, selects LUT-based storage.
REQ-005 SHALL have port clk, input, 1 bit: clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port valid_in, input, 1 bit: upstream payload valid.
REQ-008 SHALL have port ready_in, output, 1 bit: buffer can accept this cycle.
REQ-009 SHALL have port data_in, input, DATAW bits: upstream payload.
REQ-010 SHALL have port valid_out, output, 1 bit: downstream payload valid.
REQ-011 SHALL have port ready_out, input, 1 bit: downstream accepts this cycle.
REQ-012 SHALL have port data_out, output, DATAW bits: downstream payload.

Function
REQ-013 SHALL count an input transfer on the cycle where valid_in and ready_in are both high, and an output transfer on the cycle where valid_out and ready_out are both high.
REQ-014 SHALL deliver payloads in order, with no loss and no duplication.
REQ-015 SHALL hold valid_out and data_out stable while valid_out is high and ready_out is low.
REQ-016 For SIZE=0, SHALL be purely combinational: valid_out=valid_in, data_out=data_in, ready_in=ready_out.
REQ-017 For SIZE=1, SHALL use a single output register; ready_in = !valid_out || ready_out (a combinational path is permitted); when the register is full and ready_out is high, SHALL accept and pop in the same cycle, sustaining 1 transfer/cycle.
REQ-018 For SIZE=2 (skid buffer), SHALL use an output register plus one skid register; ready_in SHALL be driven from a flop, with no combinational path from ready_out.
REQ-019 For SIZE=2, when an input is accepted while the output register is full and ready_out is low, SHALL store the payload in the skid register and drive ready_in low from the next cycle.
REQ-020 For SIZE=2, on an output transfer with the skid register full, SHALL move the skid payload to the output register and drive ready_in high from the next cycle.
REQ-021 For SIZE=2, SHALL sustain 1 transfer/cycle while ready_out stays high.
REQ-022 For SIZE>=4, SHALL wrap the FIFO sub-module with push = valid_in && !full, pop = valid_out && ready_out, ready_in = !full, valid_out = !empty.
REQ-023 For SIZE>=4, a simultaneous push and pop when one entry is held SHALL keep valid_out high and present the new payload next.
REQ-024 For SIZE>=1, latency from input transfer to valid_out SHALL be 1 cycle when the buffer is empty.
REQ-025 For SIZE>=1, occupancy SHALL never exceed SIZE; a valid_in arriving while ready_in is low SHALL not be consumed.

Reset
REQ-026 On reset, SHALL drive valid_out to 0 and ready_in to 1 (SIZE>=1), with all entries discarded.
REQ-027 Reset asserted mid-operation SHALL drop buffered payloads within 1 cycle; data_out is don't-care while valid_out is 0.
REQ-028 Payload registers SHALL not require reset.

Structure
REQ-029 SHALL require no shared-package typedefs; all sizing SHALL be derived from parameters.
REQ-030 SHALL instantiate one sub-module, VX_fifo_queue, for SIZE>=4 only, forwarding DATAW, SIZE, OUTPUT_REG and LUTRAM.
REQ-031 SHALL statically assert that SIZE is legal per REQ-002.

Verification
REQ-032 Test SIZE=2, ready_out held high, valid_in high for 8 cycles with data 0..7: data_out SHALL be 0..7 on consecutive cycles after 1 cycle of latency, with ready_in never low.
REQ-033 Test SIZE=2, with 0xA accepted and then ready_out dropped while 0xB is sent: 0xB SHALL go to the skid register, ready_in SHALL be low next cycle, and data_out SHALL hold 0xA; after ready_out rises, SHALL output 0xA then 0xB.
REQ-034 Test SIZE=1, register full with 0x5 and valid_in=1 with 0x6 and ready_out=1 in the same cycle: ready_in SHALL be 1, and data_out SHALL be 0x6 next cycle.
REQ-035 Test SIZE=4, 4 pushes with ready_out=0: ready_in SHALL go low after the 4th; then 4 pops SHALL return the data in order, with valid_out low afterwards.
REQ-036 Test any SIZE>=1, reset asserted with 2 entries held: the next cycle SHALL show valid_out=0 and ready_in=1, and no stale payload SHALL appear afterwards.
REQ-037 Test random valid_in/ready_out at 50% for 10k cycles against a reference queue, for all SIZE values: SHALL produce no mismatch and no hold violation under REQ-015.
